// File: rtl/keypad_timer_entry_pkg.sv
// Shared types for the keypad timer entry block:
// debounce FSM encoding and key-code width.
package keypad_timer_entry_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

endpackage

// File: rtl/keypad_timer_entry_pulse_divider.sv
// Free-running divider: one-cycle pgt pulse
// every CLK_DIV clocks, on the last count value.
module pulse_divider #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic clrn,
    output logic pgt
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign pgt = (cnt == LAST);

endmodule

// File: rtl/keypad_timer_entry.sv
// Keypad digit entry: debounced single-key accept,
// shift-in digit buffer, and a 1 Hz tick.
module keypad_timer_entry #(
    parameter int NKEYS    = 10,
    parameter int DIGITS   = 4,
    parameter int DEBOUNCE = 3,
    parameter int CLK_DIV  = 100
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [NKEYS-1:0]    kbd,
    input  logic                enn,
    input  logic                clr,
    output logic [3:0]          D,
    output logic                loadn,
    output logic [4*DIGITS-1:0] digits,
    output logic [3:0]          count,
    output logic                full,
    output logic                multi,
    output logic                pgt_1Hz
);

    import keypad_timer_entry_pkg::*;

    localparam int DW = 4 * DIGITS;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE - 1);

    state_t             state;
    state_t             state_nx;
    logic [NKEYS-1:0]   pat;
    logic [CW-1:0]      stab;
    logic [CODE_W-1:0]  code;
    logic               single;
    logic               same;
    logic               accept;
    logic               load;

    // x & (x-1) is nonzero exactly when two or more bits are set
    assign multi  = |(kbd & (kbd - NKEYS'(1)));
    assign single = (kbd != '0) && !multi;
    assign same   = (kbd == pat);
    assign full   = (count == 4'(DIGITS));
    assign load   = accept && !enn && !full && !clr;

    always_comb begin
        code = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (pat[i]) begin
                code = CODE_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (single) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (!same) begin
                    state_nx = IDLE;
                end else if (stab == STABLE_LAST) begin
                    accept   = 1'b1;
                    state_nx = HELD;
                end
            end
            HELD: begin
                if (kbd == '0) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state <= IDLE;
            pat   <= '0;
            stab  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                pat  <= kbd;
                stab <= '0;
            end else if (state == SETTLE && stab != STABLE_LAST) begin
                stab <= stab + CW'(1);
            end
        end
    end

    // clear takes priority over a load landing on the same edge
    always_ff @(posedge clk) begin
        if (!clrn) begin
            D      <= '0;
            loadn  <= 1'b1;
            digits <= '0;
            count  <= '0;
        end else begin
            loadn <= !load;
            if (clr) begin
                digits <= '0;
                count  <= '0;
            end else if (load) begin
                D      <= code;
                digits <= (digits << CODE_W) | DW'(code);
                count  <= count + 4'd1;
            end
        end
    end

    pulse_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .clrn (clrn),
        .pgt  (pgt_1Hz)
    );

endmodule

// File: tb/tb_keypad_timer_entry.sv
// Directed bench for keypad_timer_entry: vector table
// plus hand sequences for latency, clear/reset races and the tick.
module tb_keypad_timer_entry;

    logic        clk;
    logic        clrn;
    logic [9:0]  kbd;
    logic        enn;
    logic        clr;
    logic [3:0]  D;
    logic        loadn;
    logic [15:0] digits;
    logic [3:0]  count;
    logic        full;
    logic        multi;
    logic        pgt_1Hz;

    int n_vec = 0;
    int n_bad = 0;

    keypad_timer_entry #(
        .NKEYS    (10),
        .DIGITS   (4),
        .DEBOUNCE (3),
        .CLK_DIV  (100)
    ) dut (
        .clk     (clk),
        .clrn    (clrn),
        .kbd     (kbd),
        .enn     (enn),
        .clr     (clr),
        .D       (D),
        .loadn   (loadn),
        .digits  (digits),
        .count   (count),
        .full    (full),
        .multi   (multi),
        .pgt_1Hz (pgt_1Hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  kbd;
        logic        enn;
        logic        clr;
        int          ncyc;
        int          pulses;
        logic [3:0]  d;
        logic [15:0] digits;
        logic [3:0]  count;
        logic        full;
        logic        multi;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [9:0] k, input logic e, input logic c,
        input int n, input int p, input logic [3:0] d,
        input logic [15:0] dg, input logic [3:0] cn,
        input logic f, input logic m);
        vec_t v;
        v.kbd = k; v.enn = e; v.clr = c; v.ncyc = n;
        v.pulses = p; v.d = d; v.digits = dg; v.count = cn;
        v.full = f; v.multi = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic steps(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!loadn) p++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int p;
        kbd = v.kbd; enn = v.enn; clr = v.clr;
        steps(v.ncyc, p);
        chk($sformatf("v%0d pulses", idx), p, v.pulses);
        chk($sformatf("v%0d D", idx), D, v.d);
        chk($sformatf("v%0d digits", idx), digits, v.digits);
        chk($sformatf("v%0d count", idx), count, v.count);
        chk($sformatf("v%0d full", idx), full, v.full);
        chk($sformatf("v%0d multi", idx), multi, v.multi);
    endtask

    // cycles from key application to the loadn strobe, then strobe width
    task automatic latency(input string name, input logic [9:0] k,
                           input int exp_lat);
        int lat;
        lat = -1;
        kbd = k;
        for (int j = 1; j <= 20 && lat < 0; j++) begin
            @(negedge clk);
            if (!loadn) lat = j;
        end
        chk({name, " latency"}, lat, exp_lat);
        @(negedge clk);
        chk({name, " width"}, loadn, 1'b1);
    endtask

    initial begin
        int p;
        int npgt;
        int first;
        int gap_bad;
        int last;

        clrn = 1'b0; kbd = '0; enn = 1'b0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst loadn", loadn, 1'b1);
        chk("rst D", D, 4'd0);
        chk("rst digits", digits, 16'h0);
        chk("rst count", count, 4'd0);
        chk("rst full", full, 1'b0);
        chk("rst pgt", pgt_1Hz, 1'b0);
        clrn = 1'b1;

        tbl.push_back(mk(10'h002, 0, 0, 10, 1, 4'd1, 16'h0001, 4'd1, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd1, 16'h0001, 4'd1, 0, 0));
        tbl.push_back(mk(10'h080, 0, 0, 10, 1, 4'd7, 16'h0017, 4'd2, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd7, 16'h0017, 4'd2, 0, 0));
        tbl.push_back(mk(10'h082, 0, 0, 10, 0, 4'd7, 16'h0017, 4'd2, 0, 1));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd7, 16'h0017, 4'd2, 0, 0));
        tbl.push_back(mk(10'h008, 1, 0, 10, 0, 4'd7, 16'h0017, 4'd2, 0, 0));
        tbl.push_back(mk(10'h000, 1, 0,  2, 0, 4'd7, 16'h0017, 4'd2, 0, 0));
        tbl.push_back(mk(10'h000, 0, 1,  1, 0, 4'd7, 16'h0000, 4'd0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  1, 0, 4'd7, 16'h0000, 4'd0, 0, 0));
        tbl.push_back(mk(10'h002, 0, 0, 10, 1, 4'd1, 16'h0001, 4'd1, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd1, 16'h0001, 4'd1, 0, 0));
        tbl.push_back(mk(10'h004, 0, 0, 10, 1, 4'd2, 16'h0012, 4'd2, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd2, 16'h0012, 4'd2, 0, 0));
        tbl.push_back(mk(10'h008, 0, 0, 10, 1, 4'd3, 16'h0123, 4'd3, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd3, 16'h0123, 4'd3, 0, 0));
        tbl.push_back(mk(10'h010, 0, 0, 10, 1, 4'd4, 16'h1234, 4'd4, 1, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd4, 16'h1234, 4'd4, 1, 0));
        tbl.push_back(mk(10'h200, 0, 0, 10, 0, 4'd4, 16'h1234, 4'd4, 1, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd4, 16'h1234, 4'd4, 1, 0));
        tbl.push_back(mk(10'h000, 0, 1,  1, 0, 4'd4, 16'h0000, 4'd0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  1, 0, 4'd4, 16'h0000, 4'd0, 0, 0));
        tbl.push_back(mk(10'h020, 0, 0,  2, 0, 4'd4, 16'h0000, 4'd0, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  5, 0, 4'd4, 16'h0000, 4'd0, 0, 0));
        tbl.push_back(mk(10'h008, 0, 0, 10, 1, 4'd3, 16'h0003, 4'd1, 0, 0));
        tbl.push_back(mk(10'h00A, 0, 0,  5, 0, 4'd3, 16'h0003, 4'd1, 0, 1));
        tbl.push_back(mk(10'h002, 0, 0,  5, 0, 4'd3, 16'h0003, 4'd1, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd3, 16'h0003, 4'd1, 0, 0));
        tbl.push_back(mk(10'h040, 1, 0, 10, 0, 4'd3, 16'h0003, 4'd1, 0, 0));
        tbl.push_back(mk(10'h040, 0, 0, 10, 0, 4'd3, 16'h0003, 4'd1, 0, 0));
        tbl.push_back(mk(10'h000, 0, 0,  2, 0, 4'd3, 16'h0003, 4'd1, 0, 0));

        foreach (tbl[i]) run_vec(tbl[i], i);

        // key 0: strobe 4 cycles after application, one cycle wide
        latency("key0", 10'h001, 4);
        chk("key0 D", D, 4'd0);
        chk("key0 digits", digits, 16'h0030);
        kbd = '0;
        steps(2, p);

        // clear on the accept edge suppresses the load
        kbd = 10'h004;
        steps(3, p);
        clr = 1'b1;
        @(negedge clk);
        chk("clrrace loadn", loadn, 1'b1);
        chk("clrrace digits", digits, 16'h0000);
        chk("clrrace count", count, 4'd0);
        chk("clrrace D", D, 4'd0);
        clr = 1'b0;
        steps(6, p);
        chk("clrrace pulses", p, 0);
        kbd = '0;
        steps(2, p);

        // reset mid-SETTLE with nonzero buffer, key released during reset
        kbd = 10'h100;
        steps(10, p);
        chk("pre-rst digits", digits, 16'h0008);
        kbd = '0;
        steps(2, p);
        kbd = 10'h020;
        steps(2, p);
        clrn = 1'b0;
        kbd = '0;
        @(negedge clk);
        clrn = 1'b1;
        steps(6, p);
        chk("rstsettle pulses", p, 0);
        chk("rstsettle digits", digits, 16'h0000);
        chk("rstsettle count", count, 4'd0);

        // reset mid-HELD with key still down: re-debounced from IDLE
        kbd = 10'h002;
        steps(6, p);
        chk("held pulses", p, 1);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        latency("rsthold", 10'h002, 4);
        chk("rsthold D", D, 4'd1);
        chk("rsthold digits", digits, 16'h0001);
        chk("rsthold count", count, 4'd1);
        kbd = '0;
        steps(2, p);

        // tick: three pulses at 99, 199, 299 after reset release
        clrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        npgt = 0; first = -1; last = -1; gap_bad = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (pgt_1Hz) begin
                npgt++;
                if (first < 0) first = i;
                if (last >= 0 && i - last != 100) gap_bad++;
                last = i;
            end
        end
        chk("pgt count", npgt, 3);
        chk("pgt first", first, 99);
        chk("pgt spacing", gap_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_timer_entry.md
KEYPAD_TIMER_ENTRY -- requirements
Module: keypad_timer_entry

Interface
REQ-001 Parameter NKEYS, default 10, number of keypad lines (legal range 2..16).
REQ-002 Parameter DIGITS, default 4, depth of the entered-digit buffer (legal range 1..8).
REQ-003 Parameter DEBOUNCE, default 3, cycles a single-key pattern must be stable before acceptance (legal range >= 1).
REQ-004 Parameter CLK_DIV, default 100, clock cycles per pgt_1Hz period (legal range >= 2).
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 clrn  in  1  reset; synchronous and active-low.
REQ-007 kbd  in  NKEYS  key lines, active-high, bit i = key i.
REQ-008 enn  in  1  entry enable, active-low.
REQ-009 clr  in  1  synchronous buffer clear, active-high.
REQ-010 D  out  4  code of the last accepted key.
REQ-011 loadn  out  1  active-low one-cycle strobe per accepted key.
REQ-012 digits  out  4*DIGITS  entered value; digit 0 (least significant) in bits [3:0].
REQ-013 count  out  4  number of digits entered, 0..DIGITS.
REQ-014 full  out  1  high when count == DIGITS.
REQ-015 multi  out  1  high while more than one kbd bit is set.
REQ-016 pgt_1Hz  out  1  one-cycle-high pulse every CLK_DIV cycles.

Function
REQ-017 Key code: the single set kbd bit i encodes to D = i.
REQ-018 Debounce FSM states: IDLE, SETTLE, HELD.
REQ-019 IDLE: exactly one kbd bit set -> SETTLE, stability counter cleared, pattern captured.
REQ-020 SETTLE: pattern unchanged for DEBOUNCE consecutive cycles -> accept event, then HELD; any pattern change -> IDLE.
REQ-021 HELD: stays until kbd == 0, then IDLE; one acceptance per press, no auto-repeat.
REQ-022 Accept event with enn == 0 and full == 0: on the next edge D <= code, loadn = 0 for exactly one cycle, digits shifts left by 4 with code in digit 0, count increments.
REQ-023 Accept event with enn == 1 or full == 1: FSM still moves to HELD; D, digits, count, loadn unchanged.
REQ-024 Latency: key applied cleanly at edge k -> loadn low in cycle k+DEBOUNCE+1.
REQ-025 multi is combinational from kbd; a multi-key pattern in IDLE or SETTLE returns/holds FSM in IDLE; multi during HELD has no effect.
REQ-026 clr == 1: digits <= 0, count <= 0 on that edge; clr wins over a simultaneous accept (no load, loadn stays 1, D unchanged).
REQ-027 enn changes do not reset the FSM; a key held across an enn 1->0 edge after acceptance is not re-accepted.
REQ-028 Divider counts 0..CLK_DIV-1 and wraps; pgt_1Hz = 1 exactly when count value == CLK_DIV-1; free-running, independent of enn and clr.
REQ-029 Count width 4 bits; digits never wraps beyond DIGITS (oldest digit discarded only as REQ-022 with full == 0, so no discard occurs).

Reset
REQ-030 clrn == 0 at an edge: FSM IDLE, D = 0, loadn = 1, digits = 0, count = 0, divider = 0, pgt_1Hz = 0.
REQ-031 Reset mid-SETTLE or mid-HELD discards the press; a key still held after release of reset must be stable DEBOUNCE cycles from IDLE before acceptance.
REQ-032 Reset wins over clr and accept in the same cycle.

Structure
REQ-033 Shared package holds FSM state encoding (IDLE, SETTLE, HELD) and the 4-bit key-code width constant.
REQ-034 Divider is a sub-module pulse_divider (parameter CLK_DIV, ports clk, clrn, pgt); the remainder is flat in keypad_timer_entry.

Verification
REQ-035 Reset: clrn = 0 for 2 cycles -> loadn = 1, D = 0, digits = 0, count = 0, pgt_1Hz = 0.
REQ-036 enn = 0, kbd = 10'b0000000010 held 10 cycles -> single loadn pulse in cycle DEBOUNCE+1 (4), D = 1, digits = 0x0001, count = 1; then kbd = 0, kbd = 10'b0010000000 -> D = 7, digits = 0x0017, count = 2.
REQ-037 enn = 0, kbd = 10'b0010000010 -> multi = 1, no loadn pulse, digits unchanged; enn = 1 with single key -> no loadn, no change.
REQ-038 Enter 4 digits 1,2,3,4 -> digits = 0x1234, full = 1; fifth key 9 -> no loadn, digits = 0x1234; clr = 1 -> digits = 0, count = 0, full = 0.
REQ-039 Glitch: key 5 held DEBOUNCE-1 cycles then released -> no loadn; clrn pulsed mid-SETTLE -> no acceptance.
REQ-040 Run 3*CLK_DIV cycles with CLK_DIV = 100 -> exactly 3 pgt_1Hz pulses, each one cycle wide, spaced 100 cycles, first at cycle 99 after reset release.
